// File: rtl/imm_ext_pipe.sv
// Multi-lane immediate extender and PC-relative adder for LA32R decode,
// registered behind a valid/ready handshake with a one-entry skid buffer.
module imm_ext_pipe #(
    parameter int LANES = 1
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [26*LANES-1:0]   in_din,
    input  logic [3*LANES-1:0]    in_ext_op,
    input  logic [32*LANES-1:0]   in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   out_ext,
    output logic [32*LANES-1:0]   out_sum
);

    // Bit 0 is the OUT valid flag, bit 1 the SKID valid flag.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t state_reg, state_next;

    logic [32*LANES-1:0] ext_comb, sum_comb;
    logic [32*LANES-1:0] out_ext_reg, out_sum_reg;
    logic [32*LANES-1:0] skid_ext_reg, skid_sum_reg;
    logic                in_fire, out_fire;
    logic                load_out_in, load_out_skid, load_skid;

    function automatic logic [31:0] ext_fn(input logic [25:0] d, input logic [2:0] op);
        logic [31:0] r;
        case (op)
            3'd0:    r = {d[24:5], 12'h000};
            3'd1:    r = {{20{d[21]}}, d[21:10]};
            3'd2:    r = {20'h00000, d[21:10]};
            3'd3:    r = {27'h0, d[14:10]};
            3'd4:    r = {{14{d[25]}}, d[25:10], 2'b00};
            3'd5:    r = {{4{d[9]}}, d[9:0], d[25:10], 2'b00};
            3'd6:    r = {{16{d[23]}}, d[23:10], 2'b00};
            default: r = {6'h00, d};
        endcase
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign ext_comb[32*gi +: 32] = ext_fn(in_din[26*gi +: 26], in_ext_op[3*gi +: 3]);
            assign sum_comb[32*gi +: 32] = in_pc[32*gi +: 32] + ext_comb[32*gi +: 32];
        end
    endgenerate

    // Taken straight from the SKID flag so ready never depends on out_ready.
    assign in_ready  = ~state_reg[1];
    assign out_valid = state_reg[0];
    assign out_ext   = out_ext_reg;
    assign out_sum   = out_sum_reg;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_next    = state_reg;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        load_out_in = 1'b1;
                        state_next  = ONE;
                    end
                end
                ONE: begin
                    if (out_fire && in_fire) begin
                        load_out_in = 1'b1;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end else if (in_fire) begin
                        load_skid  = 1'b1;
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        load_out_skid = 1'b1;
                        state_next    = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            out_ext_reg  <= '0;
            out_sum_reg  <= '0;
            skid_ext_reg <= '0;
            skid_sum_reg <= '0;
        end else begin
            if (load_out_in) begin
                out_ext_reg <= ext_comb;
                out_sum_reg <= sum_comb;
            end else if (load_out_skid) begin
                out_ext_reg <= skid_ext_reg;
                out_sum_reg <= skid_sum_reg;
            end
            if (load_skid) begin
                skid_ext_reg <= ext_comb;
                skid_sum_reg <= sum_comb;
            end
        end
    end

endmodule
